// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its operand-issue sequencer:
// opcodes, flag bit positions and the sequencer state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Operand-issue sequencer for the external 16-bit ALU; shifts by N run as N shift-by-1 passes.
// Optional ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN: opcodes >= 8 bypass the ALU and raise res_err.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_control,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_overflow,
    input  logic               alu_negative,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic [3:0]         res_flags,
`ifdef ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN
    output logic               res_err,
`endif
    output logic               busy
);

`ifdef ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
    logic r_res_err;
    assign res_err = r_res_err;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    seq_state_t         r_state, w_next;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_acc, r_b, r_res_data;
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_res_flags, w_alu_flags;
    logic               w_accept, w_trap, w_shift;

    assign w_alu_flags[FLAG_N] = alu_negative;
    assign w_alu_flags[FLAG_V] = alu_overflow;
    assign w_alu_flags[FLAG_C] = alu_carry;
    assign w_alu_flags[FLAG_Z] = alu_zero;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_trap   = TRAP_EN && in_op[3];
    assign w_shift  = is_shift_op(in_op);

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign busy      = (r_state != S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;

    always_comb begin
        w_next      = r_state;
        alu_a       = '0;
        alu_b       = '0;
        alu_control = '0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_trap)
                        w_next = S_DONE;
                    else if (w_shift)
                        w_next = (in_shamt == '0) ? S_DONE : S_SHIFT;
                    else
                        w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_a       = r_acc;
                alu_b       = r_b;
                alu_control = r_op;
                w_next      = S_DONE;
            end
            S_SHIFT: begin
                alu_a       = r_acc;
                alu_control = r_op;
                if (r_cnt == SHAMT_W'(1))
                    w_next = S_DONE;
            end
            S_DONE: begin
                if (res_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_acc       <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_res_data  <= '0;
            r_res_flags <= '0;
`ifdef ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN
            r_res_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= in_op;
                        r_acc <= in_a;
                        r_b   <= in_b;
                        r_cnt <= in_shamt;
`ifdef ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN
                        r_res_err <= w_trap;
`endif
                        if (w_trap) begin
                            r_res_data  <= '0;
                            r_res_flags <= '0;
                        end else if (w_shift && (in_shamt == '0)) begin
                            // zero-length shift never touches the ALU; flags derive from A
                            r_res_data          <= in_a;
                            r_res_flags         <= '0;
                            r_res_flags[FLAG_N] <= in_a[WIDTH-1];
                            r_res_flags[FLAG_Z] <= (in_a == '0);
                        end
                    end
                end
                S_EXEC: begin
                    r_res_data  <= alu_out;
                    r_res_flags <= w_alu_flags;
                end
                S_SHIFT: begin
                    r_acc <= alu_out;
                    r_cnt <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_res_data  <= alu_out;
                        r_res_flags <= w_alu_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Bench for alu_shift_seq: behavioural ALU attached to the DUT, directed plus random
// requests checked against a whole-operation reference model (ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN aware).
module tb_alu_shift_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, res_valid, res_ready, busy;
    logic [3:0]  in_op, alu_control, res_flags, in_shamt;
    logic [15:0] in_a, in_b, alu_a, alu_b, alu_out, res_data;
    logic        alu_zero, alu_carry, alu_overflow, alu_negative;
`ifdef ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN
    logic        res_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_shift_seq #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_negative(alu_negative),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags),
`ifdef ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN
        .res_err(res_err),
`endif
        .busy(busy)
    );

    // External single-pass ALU; shift opcodes shift by exactly one bit.
    always_comb begin
        logic [16:0] t;
        t            = '0;
        alu_out      = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_control)
            4'd0: begin
                t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_out = t[15:0]; alu_carry = t[16];
                alu_overflow = (alu_a[15] == alu_b[15]) && (t[15] != alu_a[15]);
            end
            4'd1: begin
                t = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
                alu_out = t[15:0]; alu_carry = t[16];
                alu_overflow = (alu_a[15] != alu_b[15]) && (t[15] != alu_a[15]);
            end
            4'd2: alu_out = alu_a & alu_b;
            4'd3: alu_out = alu_a | alu_b;
            4'd4: alu_out = alu_a ^ alu_b;
            4'd5: begin alu_out = {alu_a[14:0], 1'b0};       alu_carry = alu_a[15]; end
            4'd6: begin alu_out = {1'b0, alu_a[15:1]};       alu_carry = alu_a[0];  end
            4'd7: begin alu_out = {alu_a[15], alu_a[15:1]};  alu_carry = alu_a[0];  end
            default: alu_out = '0;
        endcase
        alu_zero     = (alu_out == 16'd0);
        alu_negative = alu_out[15];
    end

`ifdef ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN
    localparam bit TB_TRAP = 1'b1;
`else
    localparam bit TB_TRAP = 1'b0;
`endif

    // Whole-operation reference: result of the full request, not of individual passes.
    function automatic void ref_model(input logic [3:0] op, input logic [15:0] a, b,
                                      input logic [3:0] sh, output logic [15:0] d,
                                      output logic [3:0] f, output int lat);
        int sa, sb, r, n;
        logic c, v;
        sa = $signed(a); sb = $signed(b); n = sh;
        c = 1'b0; v = 1'b0; d = '0; lat = 2;
        case (op)
            4'd0: begin r = sa + sb; d = a + b; c = (int'(a) + int'(b)) > 65535; v = (r > 32767) || (r < -32768); end
            4'd1: begin r = sa - sb; d = a - b; c = (a >= b); v = (r > 32767) || (r < -32768); end
            4'd2: d = a & b;
            4'd3: d = a | b;
            4'd4: d = a ^ b;
            4'd5, 4'd6, 4'd7: begin
                lat = n + 1;
                if (n == 0) d = a;
                else if (op == 4'd5) begin d = a << n; c = a[16-n]; end
                else if (op == 4'd6) begin d = a >> n; c = a[n-1]; end
                else begin r = sa >>> n; d = r[15:0]; c = a[n-1]; end
            end
            default: d = '0;
        endcase
        f = {d[15], v, c, (d == 16'd0)};
        if (op >= 4'd8) begin
            f = TB_TRAP ? 4'b0000 : 4'b0001;
            lat = TB_TRAP ? 1 : 2;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, check latency, ALU usage, result, hold behaviour and retirement.
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, b,
                          input logic [3:0] sh, input int hold);
        logic [15:0] ed; logic [3:0] ef; int lat, cyc, passes, drove;
        logic nodrive;
        ref_model(op, a, b, sh, ed, ef, lat);
        nodrive = (op >= 4'd8 && TB_TRAP) || ((op >= 4'd5 && op <= 4'd7) && sh == 4'd0);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_shamt = sh;
        @(posedge clk);
        #1 in_valid = 1'b0; in_op = $urandom; in_a = $urandom; in_b = $urandom;
        cyc = 0; passes = 0; drove = 0;
        while (cyc < 40) begin
            res_ready = 1'($urandom);
            @(negedge clk);
            cyc++;
            if (res_valid) break;
            if (alu_control == op && op >= 4'd5 && op <= 4'd7) passes++;
            if (alu_a != 0 || alu_b != 0 || alu_control != 0) drove++;
            if (cyc == 1) check("busy", 32'(busy), 32'd1);
        end
        res_ready = 1'b0;
        check("latency", 32'(cyc), 32'(lat));
        if (op >= 4'd5 && op <= 4'd7) check("shift_passes", 32'(passes), 32'(sh));
        if (nodrive) check("alu_not_driven", 32'(drove), 32'd0);
        check("res_data", 32'(res_data), 32'(ed));
        check("res_flags", 32'(res_flags), 32'(ef));
`ifdef ALU_SHIFT_SEQ_ILLEGAL_TRAP_EN
        check("res_err", 32'(res_err), 32'(op >= 4'd8));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", {res_data, 12'd0, res_flags}, {ed, 12'd0, ef});
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("valid_drop", 32'(res_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_shamt = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_outputs", {res_valid, busy, res_flags, res_data}, 32'd0);
        check("rst_alu", {alu_a, alu_b[11:0], alu_control}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_op(4'd0, 16'h7FFF, 16'h0001, 4'd3, 1);   // ADD overflow to 0x8000, N=1 V=1
        run_op(4'd1, 16'h0003, 16'h0003, 4'd0, 5);   // SUB to zero, held 5 cycles
        run_op(4'd7, 16'h8000, 16'h1234, 4'd15, 0);  // SRA by 15 -> 0xFFFF
        run_op(4'd5, 16'h1234, 16'h5555, 4'd0, 0);   // SLL by 0 passes A through
        run_op(4'd6, 16'h8000, 16'h0000, 4'd4, 0);   // SRL by 4 -> 0x0800
        run_op(4'd5, 16'h8001, 16'h0000, 4'd1, 0);
        run_op(4'hA, 16'hBEEF, 16'h1111, 4'd2, 1);   // undefined opcode

        // Reset in cycle 3 of an 8-step shift abandons it.
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd5; in_a = 16'h00FF; in_shamt = 4'd8;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("midrst_no_result", 32'(res_valid), 32'd0);
        end
        run_op(4'd0, 16'd2, 16'd3, 4'd0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            op = (i % 9 == 8) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            run_op(op, 16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
